uart2wb: RTL and testbench
==========================

# uart2wb

Serial-to-Wishbone bridge: a UART-driven Wishbone classic initiator that lets a host PC read and write any bus address (program load, memory and peripheral poke/peek) without the CPU. It is the opposite end of `wb2uart`. `wb2uart` is a bus responder that serializes CPU accesses; `uart2wb` decodes host command frames into bus cycles and serializes the results back to the host. It sits in `top` beside `wb_copperv` as a second bus initiator.

## Interface
- `addr_width`, 32: Wishbone address width; frame format is fixed at 32.
- `data_width`, 32: Wishbone data width; frame format is fixed at 32.
- `clk_per_bit`, 217: clock cycles per UART bit (115200 baud at 25 MHz).
- `timeout_cycles`, 1024: cycles to wait for `wb_ack`; used only with the timeout feature.
- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial in, 8N1, idle high; asynchronous to `clock`.
- `uart_tx`  out  1  serial out, 8N1, idle high.
- `wb_adr`  out  addr_width  bus address.
- `wb_datwr`  out  data_width  write data.
- `wb_datrd`  in  data_width  read data; valid when `wb_ack` is high.
- `wb_we`  out  1  write enable.
- `wb_sel`  out  data_width/8  byte lane select.
- `wb_stb`  out  1  strobe.
- `wb_cyc`  out  1  cycle valid.
- `wb_ack`  in  1  responder acknowledge.

## Operation
- Command byte, bits [7:0]:
  - bit7 = write.
  - bits6:4 must be 000; any other value discards the byte and the state stays IDLE.
  - bits3:0 = `wb_sel`.
- Read frame: cmd, then addr[7:0], [15:8], [23:16], [31:24].
- Write frame: same as read, then 4 data bytes, little-endian.
- Responses:
  - Write ack: single byte 0xAA.
  - Read: 4 data bytes, little-endian.
  - Timeout: single byte 0xEE.
- FSM states: IDLE → ADDR → (DATA if write) → BUS → RESP → IDLE.
  - IDLE: a valid cmd byte latches we/sel and goes to ADDR.
  - ADDR: counts 4 bytes; when done, a write goes to DATA and a read goes to BUS.
  - DATA: counts 4 bytes, then goes to BUS.
  - BUS: `wb_cyc`=`wb_stb`=1 with adr/datwr/we/sel held stable until `wb_ack` is sampled high. On ack, read data is latched and the state goes to RESP.
  - RESP: queues 1 or 4 bytes to the transmitter, then returns to IDLE.
- RX framing error (stop bit sampled 0): the byte is dropped and the FSM returns to IDLE from any pre-BUS state.
- RX bytes that complete while in BUS or RESP are dropped. There is no buffering.
- Byte counter is 2 bits and is cleared on every state entry.

## Timing
- RX:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A start bit is confirmed at half-bit (`clk_per_bit`/2 cycles), then each bit is sampled every `clk_per_bit` cycles, LSB first.
  - The byte is valid on the stop-bit sample cycle.
- Last frame byte valid in cycle N → `wb_cyc`/`wb_stb` high in cycle N+1.
- `wb_ack` sampled high in cycle M:
  - `wb_cyc`/`wb_stb`/`wb_we` are low in cycle M+1.
  - The TX start bit drives `uart_tx` low from cycle M+1.
- TX: 10 bits of `clk_per_bit` cycles each. Response bytes go back-to-back: the next start bit follows the previous stop bit immediately.
- Every frame runs one bus cycle, even with `wb_sel`=0. No pipelining; at most one outstanding cycle.
- Reset (asynchronous, any time, including mid-cycle or mid-byte):
  - `uart_tx`=1.
  - `wb_cyc`=`wb_stb`=`wb_we`=0.
  - `wb_adr`=0, `wb_datwr`=0, `wb_sel`=0.
  - FSM in IDLE; any partial frame or byte is lost.

## Configuration
- `UART2WB_TIMEOUT_EN` defined:
  - A counter runs in BUS.
  - After `timeout_cycles` cycles without ack, `wb_cyc`/`wb_stb` drop the next cycle and 0xEE is sent in place of the normal response.
  - An ack arriving in the same cycle the count expires wins.
- Not defined: no counter is built; BUS waits indefinitely for `wb_ack`.

## Structure
- Shared package/header (`copperv_h.v` style):
  - Frame constants: `CMD_WRITE_BIT`, `RESP_ACK`=0xAA, `RESP_TIMEOUT`=0xEE.
  - FSM state encodings.
- One sub-module, `uart_phy`: RX synchronizer and deserializer plus TX serializer.
  - Byte-wide valid/ready handshake toward the bridge.
  - Flags the RX framing error.
  - Parameterized by `clk_per_bit`.
  - Reusable by `wb2uart`.

## Test plan
- Write:
  - Stimulus: host sends 0x8F, 00 10 00 00, EF BE AD DE.
  - Response: one cycle with adr=0x00001000, datwr=0xDEADBEEF, we=1, sel=0xF; after ack, `uart_tx` emits 0xAA.
- Read:
  - Stimulus: host sends 0x03, 04 00 00 00; responder acks after 3 cycles with 0x12345678.
  - Response: sel=0x3, we=0; `uart_tx` emits 78 56 34 12 back-to-back.
- Bad command and framing error:
  - Stimulus: 0x70, then a byte with stop bit 0.
  - Response: no bus cycle, no response; a following valid read frame works normally.
- Timeout (with `UART2WB_TIMEOUT_EN`, `timeout_cycles`=16):
  - Stimulus: a read frame with ack never asserted.
  - Response: cyc drops after 16 cycles, 0xEE is sent, and the next frame succeeds.
- Reset mid-BUS:
  - Stimulus: `reset` pulsed low while cyc=1.
  - Response: all outputs go to reset values asynchronously; no response byte is sent.
- Busy drop:
  - Stimulus: extra bytes arrive during RESP.
  - Response: they are ignored; the response bytes are unchanged.

Source files
------------

// File: rtl/uart2wb_pkg.sv
// Shared constants, state encodings and command decode for the UART-to-Wishbone bridge.
// The optional bus watchdog is enabled by defining UART2WB_TIMEOUT_EN.
package uart2wb_pkg;

    localparam int         CMD_WRITE_BIT = 7;
    localparam logic [7:0] RESP_ACK      = 8'hAA;
    localparam logic [7:0] RESP_TIMEOUT  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } bridge_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    // Bits 6:4 are reserved; anything non-zero there is not a command.
    function automatic logic cmd_valid(input logic [7:0] cmd);
        return cmd[6:4] == 3'b000;
    endfunction

endpackage

// File: rtl/uart2wb_uart_phy.sv
// 8N1 UART PHY: synchronized RX deserializer with framing-error flag and a
// valid/ready TX serializer that can chain bytes with no idle gap.
module uart_phy
    import uart2wb_pkg::*;
#(
    parameter int clk_per_bit = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int            CW        = $clog2(clk_per_bit);
    localparam logic [CW-1:0] BIT_LAST  = CW'(clk_per_bit - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(clk_per_bit / 2 - 1);

    logic          rx_meta, rx_sync;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_shift;
    logic          tx_accept, tx_last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_n;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_state_n = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_cnt == BIT_LAST) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else if ((rx_state == RX_START && rx_cnt == HALF_LAST) || rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    assign rx_data      = rx_shift;
    assign rx_valid     = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) &&  rx_sync;
    assign rx_frame_err = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && !rx_sync;

    // Ready during the final stop-bit cycle lets the next start bit follow immediately.
    assign tx_last   = (tx_state == TX_BUSY) && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
    assign tx_ready  = (tx_state == TX_IDLE) || tx_last;
    assign tx_accept = tx_valid && tx_ready;

    always_comb begin
        tx_state_n = tx_state;
        if (tx_accept)    tx_state_n = TX_BUSY;
        else if (tx_last) tx_state_n = TX_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            if (tx_accept) begin
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx       <= 1'b0;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state == TX_BUSY) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    tx_bit   <= tx_bit + 4'd1;
                    tx       <= tx_shift[1];
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart2wb.sv
// UART-driven Wishbone classic initiator: host frames become single bus cycles and
// results go back over serial. Define UART2WB_TIMEOUT_EN to add the ack watchdog.
module uart2wb
    import uart2wb_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int clk_per_bit    = 217,
    parameter int timeout_cycles = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_datwr,
    input  logic [data_width-1:0]   wb_datrd,
    output logic                    wb_we,
    output logic [data_width/8-1:0] wb_sel,
    output logic                    wb_stb,
    output logic                    wb_cyc,
    input  logic                    wb_ack
);

    localparam int SEL_W = data_width / 8;

    logic [7:0]            rx_data, tx_data;
    logic                  rx_valid, rx_frame_err, tx_valid, tx_ready;

    bridge_state_t         state, state_n;
    logic [1:0]            byte_cnt;
    logic                  we_r;
    logic [data_width-1:0] resp_word, resp_word_n;
    logic [1:0]            resp_last;
    logic [2:0]            resp_idx;
    logic                  tmo_hit, bus_done;

    uart_phy #(
        .clk_per_bit (clk_per_bit)
    ) u_phy (
        .clock        (clock),
        .reset        (reset),
        .rx           (uart_rx),
        .tx           (uart_tx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

`ifdef UART2WB_TIMEOUT_EN
    localparam int            TW       = $clog2(timeout_cycles + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                tmo_cnt <= '0;
        else if (state != ST_BUS)  tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + 1'b1;
    end

    // An ack landing on the expiry cycle takes priority over the timeout.
    assign tmo_hit = (state == ST_BUS) && !wb_ack && (tmo_cnt == TMO_LAST);
`else
    if (timeout_cycles < 1) begin : g_no_watchdog
    end
    assign tmo_hit = 1'b0;
`endif

    assign bus_done = (state == ST_BUS) && (wb_ack || tmo_hit);
    assign wb_cyc   = (state == ST_BUS);
    assign wb_stb   = (state == ST_BUS);
    assign wb_we    = (state == ST_BUS) && we_r;

    always_comb begin
        if (!wb_ack)   resp_word_n = {{(data_width-8){1'b0}}, RESP_TIMEOUT};
        else if (we_r) resp_word_n = {{(data_width-8){1'b0}}, RESP_ACK};
        else           resp_word_n = wb_datrd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // The first response byte is offered on the ack cycle so the start bit leaves on the next one.
    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        tx_data  = resp_word[{resp_idx[1:0], 3'b000} +: 8];
        case (state)
            ST_IDLE: begin
                if (rx_valid && cmd_valid(rx_data)) state_n = ST_ADDR;
            end
            ST_ADDR: begin
                if (rx_frame_err)                        state_n = ST_IDLE;
                else if (rx_valid && byte_cnt == 2'd3)   state_n = we_r ? ST_DATA : ST_BUS;
            end
            ST_DATA: begin
                if (rx_frame_err)                        state_n = ST_IDLE;
                else if (rx_valid && byte_cnt == 2'd3)   state_n = ST_BUS;
            end
            ST_BUS: begin
                if (bus_done) begin
                    state_n  = ST_RESP;
                    tx_valid = 1'b1;
                    tx_data  = resp_word_n[7:0];
                end
            end
            ST_RESP: begin
                if (resp_idx > {1'b0, resp_last}) state_n  = ST_IDLE;
                else                              tx_valid = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt  <= '0;
            we_r      <= 1'b0;
            wb_sel    <= '0;
            wb_adr    <= '0;
            wb_datwr  <= '0;
            resp_word <= '0;
            resp_last <= '0;
            resp_idx  <= '0;
        end else begin
            if (state_n != state)
                byte_cnt <= '0;
            else if (rx_valid && (state == ST_ADDR || state == ST_DATA))
                byte_cnt <= byte_cnt + 2'd1;

            case (state)
                ST_IDLE: begin
                    if (rx_valid && cmd_valid(rx_data)) begin
                        we_r   <= rx_data[CMD_WRITE_BIT];
                        wb_sel <= rx_data[SEL_W-1:0];
                    end
                end
                ST_ADDR: if (rx_valid) wb_adr   <= {rx_data, wb_adr[addr_width-1:8]};
                ST_DATA: if (rx_valid) wb_datwr <= {rx_data, wb_datwr[data_width-1:8]};
                ST_BUS: begin
                    if (bus_done) begin
                        resp_word <= resp_word_n;
                        resp_last <= (wb_ack && !we_r) ? 2'd3 : 2'd0;
                        resp_idx  <= tx_ready ? 3'd1 : 3'd0;
                    end
                end
                ST_RESP: if (tx_valid && tx_ready) resp_idx <= resp_idx + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart2wb.sv
// Self-checking bench for uart2wb: table-driven frames with a scoreboard of expected
// serial responses, plus hand sequences for error, busy, reset and timeout cases.
module tb_uart2wb;

    localparam int CPB      = 16;
    localparam int TMO      = 16;
    localparam int WAIT_MAX = 12 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [31:0] wb_adr, wb_datwr;
    logic [31:0] wb_datrd = '0;
    logic        wb_we, wb_stb, wb_cyc;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];
    logic mon_en   = 1'b0;
    logic mon_busy = 1'b0;
    int   cyc_cnt = 0;
    int   cyc_seen = 0;
    int   tx_low_seen = 0;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          delay;
        logic [31:0] rdat;
        logic [31:0] exp_resp;
        int          exp_nbytes;
    } vec_t;

    vec_t vecs[5];

    uart2wb #(
        .addr_width     (32),
        .data_width     (32),
        .clk_per_bit    (CPB),
        .timeout_cycles (TMO)
    ) dut (
        .clock    (clk),
        .reset    (rst_n),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .wb_adr   (wb_adr),
        .wb_datwr (wb_datwr),
        .wb_datrd (wb_datrd),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (wb_cyc)   cyc_seen    = cyc_seen + 1;
        if (!uart_tx) tx_low_seen = tx_low_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input vec_t v);
        logic [31:0] a, d;
        a = v.adr;
        d = v.wdat;
        send_byte({v.we, 3'b000, v.sel}, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
        if (v.we) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic push_expected(input vec_t v);
        logic [31:0] r;
        r = v.exp_resp;
        for (int i = 0; i < v.exp_nbytes; i++) exp_q.push_back(r[8*i +: 8]);
    endtask

    task automatic wait_cyc(output logic seen);
        int n;
        n = 0;
        while (!wb_cyc && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        seen = wb_cyc;
    endtask

    task automatic bus_cycle(input vec_t v);
        logic seen;
        wait_cyc(seen);
        check("bus_start", {31'b0, seen}, 32'd1);
        if (!seen) return;
        check("wb_adr", wb_adr, v.adr);
        check("wb_we", {31'b0, wb_we}, {31'b0, v.we});
        check("wb_sel", {28'b0, wb_sel}, {28'b0, v.sel});
        check("wb_stb", {31'b0, wb_stb}, 32'd1);
        if (v.we) check("wb_datwr", wb_datwr, v.wdat);
        repeat (v.delay) @(negedge clk);
        check("cyc_hold", {31'b0, wb_cyc}, 32'd1);
        check("adr_hold", wb_adr, v.adr);
        wb_datrd = v.rdat;
        wb_ack   = 1'b1;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_datrd = '0;
        check("cyc_drop", {31'b0, wb_cyc}, 32'd0);
        check("we_drop", {31'b0, wb_we}, 32'd0);
        check("tx_start", {31'b0, uart_tx}, 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 60 * 10 * CPB) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        push_expected(v);
        fork
            send_frame(v);
            bus_cycle(v);
        join
        wait_drain();
    endtask

    // Decodes uart_tx and compares every byte against the scoreboard.
    initial begin
        int   t, prev;
        logic have_prev;
        logic [7:0] b;
        logic stop;
        have_prev = 1'b0;
        prev = 0;
        forever begin
            @(negedge uart_tx);
            if (!rst_n || !mon_en) continue;
            mon_busy = 1'b1;
            t = cyc_cnt;
            if (have_prev && (t - prev) < 11 * CPB) check("tx_gap", t - prev, 10 * CPB);
            prev = t;
            have_prev = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            stop = uart_tx;
            check("tx_stop", {31'b0, stop}, 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL tx_unexpected: got byte 0x%02h, expected no byte", b);
            end else begin
                check("tx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation still running at 90000 cycles, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic seen;
        int   n;

        vecs[0] = '{we: 1'b1, sel: 4'hF, adr: 32'h0000_1000, wdat: 32'hDEAD_BEEF, delay: 0,
                    rdat: 32'h0, exp_resp: 32'h0000_00AA, exp_nbytes: 1};
        vecs[1] = '{we: 1'b0, sel: 4'h3, adr: 32'h0000_0004, wdat: 32'h0, delay: 3,
                    rdat: 32'h1234_5678, exp_resp: 32'h1234_5678, exp_nbytes: 4};
        vecs[2] = '{we: 1'b1, sel: 4'h0, adr: 32'hFFFF_FFFF, wdat: 32'h0000_0000, delay: 1,
                    rdat: 32'hFFFF_FFFF, exp_resp: 32'h0000_00AA, exp_nbytes: 1};
        vecs[3] = '{we: 1'b0, sel: 4'hF, adr: 32'h8000_0000, wdat: 32'h0, delay: 0,
                    rdat: 32'hA5C3_0F81, exp_resp: 32'hA5C3_0F81, exp_nbytes: 4};
        vecs[4] = '{we: 1'b1, sel: 4'h5, adr: 32'h0102_0304, wdat: 32'hCAFE_F00D, delay: 5,
                    rdat: 32'h0, exp_resp: 32'h0000_00AA, exp_nbytes: 1};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
        check("rst_stb", {31'b0, wb_stb}, 32'd0);
        check("rst_we", {31'b0, wb_we}, 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_datwr", wb_datwr, 32'd0);
        check("rst_sel", {28'b0, wb_sel}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reserved command bits, then a framing error mid-frame, then a clean read.
        cyc_seen = 0;
        send_byte(8'h70, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        check("bad_no_cyc", cyc_seen, 32'd0);
        check("bad_no_resp", exp_q.size(), 32'd0);
        run_vec(vecs[3]);

        // Bytes arriving while the read response is still being queued are dropped.
        push_expected(vecs[1]);
        fork
            send_frame(vecs[1]);
            bus_cycle(vecs[1]);
        join
        cyc_seen = 0;
        send_byte(8'h8F, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_drain();
        check("busy_no_cyc", cyc_seen, 32'd0);
        run_vec(vecs[2]);

        // Asynchronous reset while the bus cycle is open.
        v = vecs[3];
        fork
            send_frame(v);
            begin
                wait_cyc(seen);
                check("rstbus_cyc", {31'b0, seen}, 32'd1);
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("rstbus_cyc_low", {31'b0, wb_cyc}, 32'd0);
                check("rstbus_stb_low", {31'b0, wb_stb}, 32'd0);
                check("rstbus_we_low", {31'b0, wb_we}, 32'd0);
                check("rstbus_adr", wb_adr, 32'd0);
                check("rstbus_sel", {28'b0, wb_sel}, 32'd0);
                check("rstbus_tx", {31'b0, uart_tx}, 32'd1);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        cyc_seen = 0;
        tx_low_seen = 0;
        repeat (30 * CPB) @(negedge clk);
        check("rstbus_no_resp", tx_low_seen, 32'd0);
        check("rstbus_no_cyc", cyc_seen, 32'd0);
        run_vec(vecs[0]);

`ifdef UART2WB_TIMEOUT_EN
        // No ack at all: the watchdog closes the cycle and reports 0xEE.
        v = vecs[3];
        v.exp_resp   = 32'h0000_00EE;
        v.exp_nbytes = 1;
        push_expected(v);
        fork
            send_frame(v);
            begin
                wait_cyc(seen);
                check("tmo_cyc", {31'b0, seen}, 32'd1);
                n = 0;
                while (wb_cyc && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                check("tmo_len", n, TMO);
                check("tmo_tx_start", {31'b0, uart_tx}, 32'd0);
            end
        join
        wait_drain();
        run_vec(vecs[1]);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
